// File: rtl/dma_axi_pkg.sv
// Shared encodings for the DMA-side AXI4 memory responder: response codes,
// burst types, the only supported beat size, and the two channel FSM states.
package dma_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/dma_tdp_ram.sv
// Simple dual-port word RAM: one byte-enabled write port and one synchronous
// read port with enable. Read-first on same-address collisions.
module dma_tdp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Non-blocking read of mem alongside the write gives old data on collision.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dma_axi_mem_slave.sv
// AXI4 memory responder for the DMA masters: independent read and write
// channels, one outstanding burst each, INCR/FIXED bursts into on-chip RAM.
module dma_axi_mem_slave
    import dma_axi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_DEPTH_WORDS  = 1024
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int IDX_W = $clog2(C_MEM_DEPTH_WORDS);
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    // Write channel state
    wstate_t                     wstate;
    logic                        awready_q, wready_q, bvalid_q;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id;
    logic [IDX_W-1:0]            w_idx;
    logic [7:0]                  w_len, w_cnt;
    logic                        w_fixed, w_err;
    logic                        w_last_beat;

    // Read channel state
    rstate_t                     rstate;
    logic                        arready_q, rvalid_q, rlast_q, r_issue_done;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id;
    logic [IDX_W-1:0]            r_idx;
    logic [7:0]                  r_len, r_cnt;
    logic                        r_fixed, r_err;
    logic                        ren;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWBURST, S_AXI_ARBURST};

    assign w_last_beat = (w_cnt == w_len);

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wstate    <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: if (S_AXI_AWVALID) begin
                    w_id      <= S_AXI_AWID;
                    w_idx     <= S_AXI_AWADDR[2 +: IDX_W];
                    w_len     <= S_AXI_AWLEN;
                    w_fixed   <= (S_AXI_AWBURST == BURST_FIXED);
                    w_err     <= (S_AXI_AWSIZE != SIZE_4B);
                    w_cnt     <= 8'd0;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    wstate    <= W_DATA;
                end
                // The beat count, not WLAST, decides where the burst ends.
                W_DATA: if (S_AXI_WVALID) begin
                    if (!w_fixed) w_idx <= w_idx + IDX_ONE;
                    w_cnt <= w_cnt + 8'd1;
                    if (S_AXI_WLAST != w_last_beat) w_err <= 1'b1;
                    if (w_last_beat) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        wstate   <= W_RESP;
                    end
                end
                W_RESP: if (S_AXI_BREADY) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wstate    <= W_IDLE;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // One-deep read pipeline: the RAM output register is the R slot itself,
    // so it only reloads when that slot is empty or being drained.
    assign ren = (rstate == R_DATA) && !r_issue_done && (!rvalid_q || S_AXI_RREADY);

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rstate       <= R_IDLE;
            arready_q    <= 1'b1;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            r_issue_done <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: if (S_AXI_ARVALID) begin
                    r_id         <= S_AXI_ARID;
                    r_idx        <= S_AXI_ARADDR[2 +: IDX_W];
                    r_len        <= S_AXI_ARLEN;
                    r_fixed      <= (S_AXI_ARBURST == BURST_FIXED);
                    r_err        <= (S_AXI_ARSIZE != SIZE_4B);
                    r_cnt        <= 8'd0;
                    r_issue_done <= 1'b0;
                    arready_q    <= 1'b0;
                    rstate       <= R_DATA;
                end
                R_DATA: begin
                    if (ren) begin
                        rvalid_q <= 1'b1;
                        rlast_q  <= (r_cnt == r_len);
                        r_cnt    <= r_cnt + 8'd1;
                        if (!r_fixed) r_idx <= r_idx + IDX_ONE;
                        if (r_cnt == r_len) r_issue_done <= 1'b1;
                    end else if (S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                    end
                    if (rvalid_q && S_AXI_RREADY && rlast_q) begin
                        arready_q <= 1'b1;
                        rstate    <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    dma_tdp_ram #(
        .DATA_W (C_S_AXI_DATA_WIDTH),
        .DEPTH  (C_MEM_DEPTH_WORDS),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk   (S_AXI_ACLK),
        .we    (wready_q && S_AXI_WVALID),
        .waddr (w_idx),
        .wbe   (S_AXI_WSTRB),
        .wdata (S_AXI_WDATA),
        .re    (ren),
        .raddr (r_idx),
        .rdata (ram_q)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = bvalid_q ? w_id : '0;
    assign S_AXI_BRESP   = bvalid_q ? resp_of(w_err) : RESP_OKAY;

    // Payload is masked while idle so nothing stale leaks out after reset.
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rvalid_q && rlast_q;
    assign S_AXI_RID     = rvalid_q ? r_id : '0;
    assign S_AXI_RRESP   = rvalid_q ? resp_of(r_err) : RESP_OKAY;
    assign S_AXI_RDATA   = rvalid_q ? ram_q : '0;

endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// Directed bench for dma_axi_mem_slave: bursts, strobes, stalls, errors, reset.
module tb_dma_axi_mem_slave;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    dma_axi_mem_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] wr_data [0:255];
    logic [31:0] rd_data [0:255];
    logic [1:0]  rd_resp [0:255];
    logic        wr_timeout, rd_timeout, rd_arready_after, rd_rid;
    logic [1:0]  wr_bresp;
    logic        wr_bid;
    int          wr_wlat, wr_blat;
    int          rd_beats, rd_first, rd_last_k, rd_unstable, rd_arready_bad;

    task automatic axi_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [3:0] strb, input int wlast_at);
        int n;
        wr_timeout = 1'b0;
        wr_wlat = -1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) wr_timeout = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wr_data[i]; wstrb = strb; wlast = (i == wlast_at); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) wr_timeout = 1'b1;
            if (i == 0) wr_wlat = n;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) wr_timeout = 1'b1;
        wr_blat = n; wr_bresp = bresp; wr_bid = bid;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // k counts cycles from the AR handshake cycle (k=0).
    task automatic axi_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] rpat, input int max_beats);
        int k;
        logic stalled;
        logic [31:0] prev;
        rd_beats = 0; rd_first = -1; rd_last_k = -1; rd_unstable = 0;
        rd_arready_bad = 0; rd_timeout = 1'b0; rd_arready_after = 1'b0; rd_rid = 1'b0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) rd_timeout = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        k = 1; stalled = 1'b0; prev = '0;
        while (k < 200) begin
            rready = rpat[(k-1) % 4];
            if (rvalid && rd_first < 0) rd_first = k;
            if (stalled && (!rvalid || rdata !== prev)) rd_unstable++;
            if (arready) rd_arready_bad++;
            if (rvalid && rready) begin
                rd_data[rd_beats] = rdata;
                rd_resp[rd_beats] = rresp;
                rd_rid = rid;
                rd_beats++;
                if (rlast) rd_last_k = k;
            end
            stalled = rvalid && !rready;
            prev = rdata;
            if (rd_last_k >= 0 || rd_beats >= max_beats) break;
            @(negedge clk);
            k++;
        end
        if (k >= 200) rd_timeout = 1'b1;
        if (rd_last_k >= 0) begin
            @(negedge clk);
            rready = 1'b0;
            rd_arready_after = arready;
        end
    endtask

    task automatic test_reset;
        logic [43:0] obs, exp;
        exp = {2'b11, 42'd0};
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        obs = {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, exp); end
        aresetn = 1'b1;
        @(negedge clk);
        obs = {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL post_reset_outputs got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_incr_write;
        for (int i = 0; i < 16; i++) wr_data[i] = i;
        axi_write(1'b1, 32'h4000_0000, 8'd15, 3'b010, 2'b01, 4'hF, 15);
        checks++;
        if (wr_timeout !== 1'b0) begin failures++; $display("FAIL incr_wr_timeout got=%0d exp=0", wr_timeout); end
        checks++;
        if (wr_wlat !== 0) begin failures++; $display("FAIL incr_wr_wready_latency got=%0d exp=0", wr_wlat); end
        checks++;
        if (wr_blat !== 0) begin failures++; $display("FAIL incr_wr_bvalid_latency got=%0d exp=0", wr_blat); end
        checks++;
        if (wr_bresp !== 2'b00) begin failures++; $display("FAIL incr_wr_bresp got=%0h exp=0", wr_bresp); end
        checks++;
        if (wr_bid !== 1'b1) begin failures++; $display("FAIL incr_wr_bid got=%0h exp=1", wr_bid); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut.u_ram.mem[i] !== 32'(i)) begin
                failures++; $display("FAIL incr_wr_mem[%0d] got=%h exp=%h", i, dut.u_ram.mem[i], 32'(i));
            end
        end
    endtask

    task automatic test_incr_read;
        int bad;
        axi_read(1'b1, 32'h4000_0000, 8'd15, 3'b010, 2'b01, 4'b1111, 256);
        checks++;
        if (rd_timeout !== 1'b0 || rd_beats !== 16) begin
            failures++; $display("FAIL incr_rd_beats got=%0d exp=16 timeout=%0d", rd_beats, rd_timeout);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (rd_data[i] !== 32'(i) || rd_resp[i] !== 2'b00) bad++;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL incr_rd_data bad_beats=%0d exp=0", bad); end
        checks++;
        if (rd_first !== 2) begin failures++; $display("FAIL incr_rd_first_rvalid got=%0d exp=2", rd_first); end
        checks++;
        if (rd_last_k !== 17) begin failures++; $display("FAIL incr_rd_rlast_cycle got=%0d exp=17", rd_last_k); end
        checks++;
        if (rd_rid !== 1'b1) begin failures++; $display("FAIL incr_rd_rid got=%0h exp=1", rd_rid); end
        checks++;
        if (rd_arready_bad !== 0 || rd_arready_after !== 1'b1) begin
            failures++; $display("FAIL incr_rd_arready busy_high=%0d after=%0d exp=0/1", rd_arready_bad, rd_arready_after);
        end
    endtask

    task automatic test_rready_stall;
        int bad;
        axi_read(1'b0, 32'h4000_0000, 8'd15, 3'b010, 2'b01, 4'b1001, 256);
        checks++;
        if (rd_timeout !== 1'b0 || rd_beats !== 16 || rd_last_k < 0) begin
            failures++; $display("FAIL stall_rd_beats got=%0d exp=16 last_k=%0d", rd_beats, rd_last_k);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (rd_data[i] !== 32'(i)) bad++;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL stall_rd_sequence bad_beats=%0d exp=0", bad); end
        checks++;
        if (rd_unstable !== 0) begin failures++; $display("FAIL stall_rd_stable changes=%0d exp=0", rd_unstable); end
    endtask

    task automatic test_strobe;
        dut.u_ram.mem[100] <= 32'h1122_3344;
        @(negedge clk);
        wr_data[0] = 32'hAABB_CCDD;
        axi_write(1'b0, 32'h0000_0190, 8'd0, 3'b010, 2'b01, 4'b0101, 0);
        checks++;
        if (dut.u_ram.mem[100] !== 32'h11BB_33DD) begin
            failures++; $display("FAIL strobe_mem got=%h exp=11bb33dd", dut.u_ram.mem[100]);
        end
        axi_read(1'b0, 32'h0000_0190, 8'd0, 3'b010, 2'b01, 4'b1111, 256);
        checks++;
        if (rd_beats !== 1 || rd_data[0] !== 32'h11BB_33DD) begin
            failures++; $display("FAIL strobe_rd got=%h beats=%0d exp=11bb33dd", rd_data[0], rd_beats);
        end
    endtask

    task automatic test_error_fixed;
        int bad;
        for (int i = 0; i < 8; i++) wr_data[i] = 32'hE0 + i;
        axi_write(1'b1, 32'h0000_0200, 8'd7, 3'b001, 2'b01, 4'hF, 3);
        checks++;
        if (wr_timeout !== 1'b0 || wr_bresp !== 2'b10) begin
            failures++; $display("FAIL err_wr_bresp got=%0h timeout=%0d exp=2", wr_bresp, wr_timeout);
        end
        checks++;
        if (dut.u_ram.mem[135] !== 32'hE7) begin
            failures++; $display("FAIL err_wr_mem135 got=%h exp=e7", dut.u_ram.mem[135]);
        end
        axi_read(1'b0, 32'h0000_0200, 8'd3, 3'b010, 2'b00, 4'b1111, 256);
        bad = 0;
        for (int i = 0; i < 4; i++) if (rd_data[i] !== 32'hE0 || rd_resp[i] !== 2'b00) bad++;
        checks++;
        if (rd_beats !== 4 || bad !== 0 || rd_last_k !== 5) begin
            failures++; $display("FAIL fixed_rd beats=%0d bad=%0d last_k=%0d exp=4/0/5", rd_beats, bad, rd_last_k);
        end
        axi_read(1'b0, 32'h0000_0204, 8'd0, 3'b001, 2'b01, 4'b1111, 256);
        checks++;
        if (rd_resp[0] !== 2'b10 || rd_data[0] !== 32'hE1) begin
            failures++; $display("FAIL err_rd got resp=%0h data=%h exp=2/e1", rd_resp[0], rd_data[0]);
        end
        dut.u_ram.mem[201] <= 32'hDEAD_0000;
        @(negedge clk);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h10 + i;
        axi_write(1'b0, 32'h0000_0320, 8'd3, 3'b010, 2'b00, 4'hF, 3);
        checks++;
        if (wr_bresp !== 2'b00 || dut.u_ram.mem[200] !== 32'h13 || dut.u_ram.mem[201] !== 32'hDEAD_0000) begin
            failures++; $display("FAIL fixed_wr resp=%0h m200=%h m201=%h exp=0/13/dead0000",
                                 wr_bresp, dut.u_ram.mem[200], dut.u_ram.mem[201]);
        end
    endtask

    task automatic test_reset_mid_read;
        int bad;
        axi_read(1'b0, 32'h4000_0000, 8'd15, 3'b010, 2'b01, 4'b1111, 5);
        aresetn = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || awready !== 1'b1) begin
            failures++; $display("FAIL midreset_state rvalid=%0d arready=%0d awready=%0d exp=0/1/1", rvalid, arready, awready);
        end
        aresetn = 1'b1;
        rready = 1'b0;
        @(negedge clk);
        axi_read(1'b1, 32'h4000_0000, 8'd15, 3'b010, 2'b01, 4'b1111, 256);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rd_data[i] !== 32'(i)) bad++;
        checks++;
        if (rd_beats !== 16 || bad !== 0 || rd_last_k !== 17) begin
            failures++; $display("FAIL midreset_reread beats=%0d bad=%0d last_k=%0d exp=16/0/17", rd_beats, bad, rd_last_k);
        end
    endtask

    task automatic test_index_wrap;
        wr_data[0] = 32'h55; wr_data[1] = 32'h66;
        axi_write(1'b0, 32'h4000_0FFC, 8'd1, 3'b010, 2'b01, 4'hF, 1);
        checks++;
        if (dut.u_ram.mem[1023] !== 32'h55 || dut.u_ram.mem[0] !== 32'h66) begin
            failures++; $display("FAIL index_wrap m1023=%h m0=%h exp=55/66", dut.u_ram.mem[1023], dut.u_ram.mem[0]);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        awid = 1'b0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 1'b0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_incr_write();
        test_incr_read();
        test_rready_stall();
        test_strobe();
        test_error_fixed();
        test_reset_mid_read();
        test_index_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_axi_mem_slave.md
# dma_axi_mem_slave

AXI4-Full memory responder that serves the DMA's read master (AR/R) and write master (AW/W/B) with INCR/FIXED bursts from an on-chip word-addressed RAM. It is the bench and on-chip target for 2D DMA transfers: source images are preloaded, destination images are read back. Read and write channels run independently, with one outstanding transaction per direction.

## Interface
- C_S_AXI_ID_WIDTH, 1, ID width on AW/AR/B/R.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_MEM_DEPTH_WORDS, 1024, RAM depth in words; must be a power of 2.
- S_AXI_ACLK  in  1  single clock, rising edge.
- S_AXI_ARESETN  in  1  synchronous, active-low reset.
- S_AXI_AWID / S_AXI_ARID  in  ID_WIDTH  transaction ID, captured at the address handshake.
- S_AXI_AWADDR / S_AXI_ARADDR  in  ADDR_WIDTH  burst start byte address.
- S_AXI_AWLEN / S_AXI_ARLEN  in  8  beats-1.
- S_AXI_AWSIZE / S_AXI_ARSIZE  in  3  beat size; 3'b010 is legal.
- S_AXI_AWBURST / S_AXI_ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
- S_AXI_AWVALID / S_AXI_ARVALID  in  1; S_AXI_AWREADY / S_AXI_ARREADY  out  1.
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4  byte enables; S_AXI_WLAST  in  1; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BID  out  ID_WIDTH; S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_RID  out  ID_WIDTH; S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RLAST  out  1; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- LOCK/CACHE/PROT/QOS/USER inputs: not ported; the DMA top ties them off.

## Operation
- Word index = addr[2 +: log2(C_MEM_DEPTH_WORDS)]. Upper address bits are ignored. The index wraps modulo depth.
- Write FSM, W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: AWREADY=1. On the AW handshake, capture id, index, len, burst, and an error flag (AWSIZE≠2).
  - W_DATA: WREADY=1. Each W handshake writes the RAM with WSTRB byte enables. INCR advances the index by 1; FIXED holds it; WRAP is treated as INCR.
  - The beat counter counts up to len. The last beat is the beat where counter==len. WLAST not matching that beat sets the error flag. The FSM leaves W_DATA on the counted last beat, regardless of WLAST.
  - W_RESP: BVALID=1, BID=captured id, BRESP=SLVERR(2'b10) if the error flag is set, else OKAY. Hold until BREADY, then return to W_IDLE.
- Read FSM, R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: ARREADY=1. Capture as for AW (error flag when ARSIZE≠2).
  - R_DATA: the RAM read port is synchronous. Read enable = !RVALID | RREADY, so the pipeline advances only when the output slot is free or being consumed.
  - RDATA/RRESP/RLAST/RID stay stable while RVALID && !RREADY.
  - RLAST=1 on beat len. On the RLAST handshake, return to R_IDLE.
  - An error flag yields RRESP=SLVERR on every beat; data is still returned.
- Read and write to the same word in the same cycle: the read returns old data (read-first).

## Timing
- During reset, and on the first cycle after reset: every output is 0 except AWREADY=ARREADY=1 (both FSMs are in IDLE).
- Reset asserted mid-burst: both FSMs return to IDLE on the next edge. Outstanding beats and responses are dropped. RAM contents are preserved.
- AW handshake at cycle T → WREADY=1 from T+1. Last W handshake at T+k → BVALID at T+k+1.
- AR handshake at T → first RVALID at T+2. With RREADY held high, beats are back-to-back: an N-beat burst has RLAST at T+N+1. ARREADY=0 from T+1 until the cycle after RLAST.
- Throughput: 1 beat/cycle per direction. Read and write run concurrently.
- The bench preloads and dumps the RAM through hierarchical access to the RAM array; there is no extra port.

## Structure
- Package dma_axi_pkg: RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP, SIZE_4B, write/read FSM state encodings.
- Sub-module dma_tdp_ram: simple dual-port RAM (1 write port with 4-bit byte enable, 1 synchronous read port with enable, read-first), depth C_MEM_DEPTH_WORDS, inferable as BRAM.
- The top holds the two FSMs, address/beat counters, and response registers.

## Test plan
- Write INCR burst at 0x40000000, AWLEN=15, data 0..15, WSTRB=F → BRESP=OKAY, BVALID 1 cycle after the 16th beat; RAM words 0..15 = 0..15.
- Read INCR at 0x40000000, ARLEN=15, RREADY=1 → 16 beats data 0..15, first RVALID at T+2, RLAST at T+17, RRESP=OKAY.
- Read with RREADY toggling 1-0-0-1 → no beat lost or duplicated; RDATA stable while stalled; sequence still 0..15.
- Write WSTRB=4'b0101, data 0xAABBCCDD over 0x11223344 → read returns 0x11BB33DD.
- AWSIZE=1 with WLAST early on beat 3 of AWLEN=7 → 8 beats accepted, BRESP=SLVERR; FIXED read ARLEN=3 → same word 4 times.
- Reset in the middle of a 16-beat read → RVALID=0 next cycle, ARREADY=1; a new burst completes correctly with memory unchanged.
